// File: rtl/cordic_rotator_pipe.sv
// Fully pipelined CORDIC: ROTATE turns (x,y) by angle_in; VECTOR gives |v| and atan2.
// Ports: clk, reset (async low), in_valid/mode_in/x_in/y_in/angle_in -> out_valid/mode_out/x_out/y_out/z_out.
module cordic_rotator_pipe #(
  parameter int DATA_W     = 12,
  parameter int ANGLE_W    = 32,
  parameter int STAGES     = 12,
  parameter int GAIN_MUL   = 311,
  parameter int GAIN_SHIFT = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      mode_in,
  input  logic signed [DATA_W-1:0]  x_in,
  input  logic signed [DATA_W-1:0]  y_in,
  input  logic        [ANGLE_W-1:0] angle_in,
  output logic                      out_valid,
  output logic                      mode_out,
  output logic signed [DATA_W-1:0]  x_out,
  output logic signed [DATA_W-1:0]  y_out,
  output logic        [ANGLE_W-1:0] z_out
);

  localparam int IW = DATA_W + 2;
  localparam int GW = $clog2(GAIN_MUL + 1) + 1;
  localparam int PW = IW + GW;

  localparam logic [ANGLE_W-1:0] HALF =
    {1'b1, {(ANGLE_W-1){1'b0}}};
  localparam logic signed [PW-1:0] GM = PW'(GAIN_MUL);
  localparam logic signed [PW-1:0] SMAX =
    PW'((2 ** (DATA_W-1)) - 1);
  localparam logic signed [PW-1:0] SMIN =
    PW'(-(2 ** (DATA_W-1)));

  function automatic logic [ANGLE_W-1:0] atan_lut(input int i);
    logic [31:0] t;
    case (i)
      0:       t = 32'h20000000;
      1:       t = 32'h12E4051E;
      2:       t = 32'h09FB385B;
      3:       t = 32'h051111D4;
      4:       t = 32'h028B0D43;
      5:       t = 32'h0145D7E1;
      6:       t = 32'h00A2F61E;
      7:       t = 32'h00517C55;
      8:       t = 32'h0028BE53;
      9:       t = 32'h00145F2F;
      10:      t = 32'h000A2F98;
      11:      t = 32'h000517CC;
      12:      t = 32'h00028BE6;
      13:      t = 32'h000145F3;
      14:      t = 32'h0000A2FA;
      15:      t = 32'h0000517D;
      default: t = 32'h0;
    endcase
    t = t >> (32 - ANGLE_W);
    return t[ANGLE_W-1:0];
  endfunction

  // -(-2^(N-1)) has no N-bit encoding; clamp to +max
  function automatic logic signed [DATA_W-1:0] neg_sat(
    input logic signed [DATA_W-1:0] v
  );
    if (v == {1'b1, {(DATA_W-1){1'b0}}})
      return {1'b0, {(DATA_W-1){1'b1}}};
    return -v;
  endfunction

  function automatic logic signed [DATA_W-1:0] gain_sat(
    input logic signed [IW-1:0] v
  );
    logic signed [PW-1:0] p;
    p = $signed({{GW{v[IW-1]}}, v}) * GM;
    p = p >>> GAIN_SHIFT;
    if (p > SMAX) return SMAX[DATA_W-1:0];
    if (p < SMIN) return SMIN[DATA_W-1:0];
    return p[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] px, py;
  logic        [ANGLE_W-1:0] pz;
  logic                      flip;

  // angle bits 01/10 mean |angle| > 90 deg: rotate by 180 first
  assign flip = angle_in[ANGLE_W-1] ^ angle_in[ANGLE_W-2];

  always_comb begin
    px = x_in;
    py = y_in;
    pz = mode_in ? '0 : angle_in;
    unique case (1'b1)
      mode_in && x_in[DATA_W-1]: begin
        px = neg_sat(x_in);
        py = neg_sat(y_in);
        pz = HALF;
      end
      !mode_in && flip: begin
        px = neg_sat(x_in);
        py = neg_sat(y_in);
        pz = angle_in + HALF;
      end
      default: ;
    endcase
  end

  logic                      v0, m0;
  logic signed [IW-1:0]      x0, y0;
  logic        [ANGLE_W-1:0] z0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0 <= 1'b0;
      m0 <= 1'b0;
      x0 <= '0;
      y0 <= '0;
      z0 <= '0;
    end else begin
      v0 <= in_valid;
      m0 <= mode_in;
      x0 <= {{2{px[DATA_W-1]}}, px};
      y0 <= {{2{py[DATA_W-1]}}, py};
      z0 <= pz;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : stg
    localparam logic [ANGLE_W-1:0] AT = atan_lut(g);

    logic                      vi, mi, vr, mr;
    logic signed [IW-1:0]      xi, yi, xr, yr;
    logic signed [IW-1:0]      xs, ys;
    logic        [ANGLE_W-1:0] zi, zr;
    logic                      dpos;

    if (g == 0) begin : src
      assign vi = v0;
      assign mi = m0;
      assign xi = x0;
      assign yi = y0;
      assign zi = z0;
    end else begin : src
      assign vi = stg[g-1].vr;
      assign mi = stg[g-1].mr;
      assign xi = stg[g-1].xr;
      assign yi = stg[g-1].yr;
      assign zi = stg[g-1].zr;
    end

    assign xs = xi >>> g;
    assign ys = yi >>> g;
    // ROTATE drives z to 0; VECTOR drives y to 0
    assign dpos = mi ? yi[IW-1] : ~zi[ANGLE_W-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vr <= 1'b0;
        mr <= 1'b0;
        xr <= '0;
        yr <= '0;
        zr <= '0;
      end else begin
        vr <= vi;
        mr <= mi;
        if (dpos) begin
          xr <= xi - ys;
          yr <= yi + xs;
          zr <= zi - AT;
        end else begin
          xr <= xi + ys;
          yr <= yi - xs;
          zr <= zi + AT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      mode_out  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else begin
      out_valid <= stg[STAGES-1].vr;
      mode_out  <= stg[STAGES-1].mr;
      x_out     <= gain_sat(stg[STAGES-1].xr);
      y_out     <= gain_sat(stg[STAGES-1].yr);
      z_out     <= stg[STAGES-1].zr;
    end
  end

endmodule

// File: tb/tb_cordic_rotator_pipe.sv
// Scoreboard bench for cordic_rotator_pipe at default parameters.
// Directed vectors, mixed-mode stream with bubbles, mid-stream reset.
module tb_cordic_rotator_pipe;

  localparam int LAT  = 14;
  localparam int XTOL = 4;
  localparam int ZTOL = 1 << 21;
  localparam real PI2 = 6.283185307179586;
  localparam real K   = 1.6467602581 * 311.0 / 512.0;
  localparam real TW32 = 4294967296.0;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, mode_in;
  logic signed [11:0] x_in, y_in;
  logic [31:0] angle_in;
  logic out_valid, mode_out;
  logic signed [11:0] x_out, y_out;
  logic [31:0] z_out;

  cordic_rotator_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .mode_in(mode_in),
    .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
    .out_valid(out_valid), .mode_out(mode_out),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          mode;
    int          ex;
    int          ey;
    logic [31:0] ez;
    int          xtol;
  } exp_t;

  exp_t sbq[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(string nm, int act, int req, int tol);
    total++;
    if (act - req <= tol && req - act <= tol) passed++;
    else $display("FAIL %s: got %0d want %0d (tol %0d) cyc %0d",
                  nm, act, req, tol, cyc);
  endtask

  task automatic chkz(string nm, logic [31:0] act, logic [31:0] req);
    logic [31:0] d;
    int di;
    d = act - req;
    di = $signed(d);
    total++;
    if (di <= ZTOL && -di <= ZTOL) passed++;
    else $display("FAIL %s: got %h want %h cyc %0d",
                  nm, act, req, cyc);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL spurious out_valid: got 1 want 0 cyc %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("latency", cyc, e.cyc + LAT, 0);
          chk("mode", int'(mode_out), int'(e.mode), 0);
          chk("x", int'(x_out), e.ex, e.xtol);
          chk("y", int'(y_out), e.ey, XTOL);
          chkz("z", z_out, e.ez);
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].cyc + LAT) begin
        total++;
        $display("FAIL missing out_valid: got 0 want 1 cyc %0d", cyc);
        void'(sbq.pop_front());
      end
    end
  end

  function automatic int clampr(real r);
    if (r > 2047.0) return 2047;
    if (r < -2048.0) return -2048;
    return int'(r);
  endfunction

  task automatic mdl(input bit m, input int x, input int y,
                     input logic [31:0] a, output int ex,
                     output int ey, output logic [31:0] ez);
    real th, rx, ry, r;
    if (!m) begin
      th = real'($signed(a)) * PI2 / TW32;
      rx = K * (x * $cos(th) - y * $sin(th));
      ry = K * (x * $sin(th) + y * $cos(th));
      ez = '0;
    end else begin
      rx = K * $sqrt(real'(x * x + y * y));
      ry = 0.0;
      r = $atan2(real'(y), real'(x)) / PI2 * TW32;
      if (r < 0.0) r = r + TW32;
      ez = 32'(longint'(r));
    end
    ex = clampr(rx);
    ey = clampr(ry);
  endtask

  task automatic send(bit m, int x, int y, logic [31:0] a,
                      int ex, int ey, logic [31:0] ez, int xt);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    mode_in  = m;
    x_in     = 12'(x);
    y_in     = 12'(y);
    angle_in = a;
    e = '{cyc, m, ex, ey, ez, xt};
    sbq.push_back(e);
  endtask

  task automatic send_m(bit m, int x, int y, logic [31:0] a);
    int ex, ey;
    logic [31:0] ez;
    mdl(m, x, y, a, ex, ey, ez);
    send(m, x, y, a, ex, ey, ez, XTOL);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      mode_in  = 1'($urandom);
      x_in     = 12'($urandom);
      y_in     = 12'($urandom);
      angle_in = $urandom;
    end
  endtask

  task automatic chk_zero(string pfx);
    chk({pfx, "_valid"}, int'(out_valid), 0, 0);
    chk({pfx, "_mode"}, int'(mode_out), 0, 0);
    chk({pfx, "_x"}, int'(x_out), 0, 0);
    chk({pfx, "_y"}, int'(y_out), 0, 0);
    chk({pfx, "_z"}, int'(z_out), 0, 0);
  endtask

  typedef struct {
    bit          m;
    int          x;
    int          y;
    logic [31:0] a;
    int          ex;
    int          ey;
    logic [31:0] ez;
    int          xt;
  } vec_t;

  vec_t dv[7] = '{
    '{0, 1000, 0, 32'h20000000, 707, 707, 32'h0, 4},
    '{0, 1000, 0, 32'h80000000, -1000, 0, 32'h0, 4},
    '{0, 1000, 0, 32'hC0000000, 0, -1000, 32'h0, 4},
    '{1, 300, 400, 32'h0, 500, 0, 32'h25C80000, 4},
    '{1, -300, 400, 32'h0, 500, 0, 32'h5A380000, 4},
    '{1, 2047, 2047, 32'h0, 2047, 0, 32'h20000000, 0},
    '{0, -2048, 0, 32'h0, -2048, 0, 32'h0, 1}
  };

  int sx[20] = '{700, 900, -500, -1000, 1200, 0, 300, -800,
                 -1100, 1500, 600, 1000, 1000, -1200, 0, 700,
                 -1400, -600, 900, 400};
  int sy[20] = '{200, -600, 800, -700, 0, 1100, -900, 900,
                 -400, 100, 600, 0, 0, 0, -1000, -1400,
                 300, -1300, 900, 1600};
  logic [31:0] sa[20] = '{
    32'h15555555, 32'h12345678, 32'h9A000000, 32'hDEADBEEF,
    32'h40000000, 32'h0BADF00D, 32'hE0000000, 32'h55555555,
    32'h7FFFFFFF, 32'hCAFEF00D, 32'hC0000000, 32'h80000000,
    32'h3FFFFFFF, 32'h01234567, 32'h60000000, 32'hFFFFFFFF,
    32'h2AAAAAAA, 32'h76543210, 32'hA0000000, 32'h44444444};

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    mode_in  = 1'b0;
    x_in     = '0;
    y_in     = '0;
    angle_in = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    idle(2);

    foreach (dv[i])
      send(dv[i].m, dv[i].x, dv[i].y, dv[i].a,
           dv[i].ex, dv[i].ey, dv[i].ez, dv[i].xt);
    idle(LAT + 4);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      send_m(i[0], sx[i], sy[i], sa[i]);
    end
    idle(LAT + 4);

    for (int i = 0; i < 16; i++)
      send_m(i[0], 800, -300, 32'(i) * 32'h10000000);
    idle(1);
    #2 reset = 1'b0;
    #1 chk_zero("midrst");
    sbq.delete();
    repeat (3) @(negedge clk);
    chk_zero("held");
    reset = 1'b1;
    idle(LAT + 6);
    send_m(0, 1000, 0, 32'h20000000);
    idle(LAT + 4);

    chk("sb_empty", sbq.size(), 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
